mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a registered-read ROM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_arbiter #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_0,
  input  logic [MEM_DEPTH:0]            addr_0,
  input  logic [MEM_EXTRA-1:0]          extra_0,
  output logic                          gnt_0,
  output logic                          rvalid_0,
  output logic [(2**MEM_EXTRA)*8-1:0]   rdata_0,
  output logic                          rerror_0,
  input  logic                          req_1,
  input  logic [MEM_DEPTH:0]            addr_1,
  input  logic [MEM_EXTRA-1:0]          extra_1,
  output logic                          gnt_1,
  output logic                          rvalid_1,
  output logic [(2**MEM_EXTRA)*8-1:0]   rdata_1,
  output logic                          rerror_1,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  output logic                          busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                 r_state, w_next;
  logic                   r_owner;
  logic [MEM_DEPTH:0]     r_addr;
  logic [MEM_EXTRA-1:0]   r_extra;
  logic                   w_win, w_gnt, w_wait;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_ptr;
  assign w_win = (req_0 & req_1) ? r_ptr : req_1;
  always_ff @(posedge clk) begin
    if (reset) r_ptr <= 1'b0;
    else if (w_gnt) r_ptr <= ~w_win;
  end
`else
  assign w_win = req_1;
`endif
  assign w_gnt  = ~reset & (r_state == IDLE) & (req_0 | req_1);
  assign w_wait = ~reset & (r_state == WAIT);
  assign busy   = w_wait;
  assign w_next = w_gnt ? WAIT : IDLE;
  // Reset gates every output combinationally, so a response in flight is dropped.
  always_comb begin
    gnt_0     = w_gnt & ~w_win;
    gnt_1     = w_gnt & w_win;
    mem_addr  = w_wait ? r_addr : w_gnt ? (w_win ? addr_1 : addr_0) : '0;
    mem_extra = w_wait ? r_extra : w_gnt ? (w_win ? extra_1 : extra_0) : '0;
    rvalid_0  = w_wait & ~r_owner;
    rvalid_1  = w_wait & r_owner;
    rdata_0   = rvalid_0 ? mem_data : '0;
    rdata_1   = rvalid_1 ? mem_data : '0;
    rerror_0  = rvalid_0 & mem_error;
    rerror_1  = rvalid_1 & mem_error;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_extra <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_owner <= w_win;
        r_addr  <= mem_addr;
        r_extra <= mem_extra;
      end
    end
  end
endmodule
